// File: rtl/ps2_tx_pkg.sv
// ---------------------------------------------------------------------------
// ps2_tx_pkg
//   Shared definitions for the PS/2 host transmitter and the keyboard
//   receiver path:
//     - FSM state encoding of the transmitter (3 bits)
//     - keyboard command bytes and device response codes
//     - odd-parity helper used when latching a frame
// ---------------------------------------------------------------------------
package ps2_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RTS      = 3'd1,
    ST_START    = 3'd2,
    ST_DATA     = 3'd3,
    ST_STOP     = 3'd4,
    ST_ACK      = 3'd5,
    ST_WAIT_REL = 3'd6
  } ps2_tx_state_e;

  // Host-to-keyboard commands
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  // Keyboard-to-host codes (ACK_BYTE answers a command, BREAK prefixes a
  // key release on the receive side)
  localparam logic [7:0] ACK_BYTE    = 8'hFA;
  localparam logic [7:0] BREAK       = 8'hF0;

  // PS/2 frames carry odd parity: data bits plus parity hold an odd count
  // of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_tx_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
//   Conditions the PS/2 clock pad for use in the system clock domain.
//   A 2-FF synchronizer is followed by a debounce filter: the filtered
//   level changes only after FILTER_LEN consecutive synchronized samples
//   that disagree with it. o_fall_tick pulses for one cycle on every
//   filtered 1->0 transition. Shared with the receiver.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous reset, active-low
//   i_line      in   raw pad sample
//   o_level     out  filtered line level
//   o_fall_tick out  one-cycle pulse on filtered falling edge
// ---------------------------------------------------------------------------
module ps2_line_filter
  import ps2_tx_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_level,
  output logic o_fall_tick
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_fall;
  logic          w_sample;
  logic          w_diff;

  assign w_sample = r_sync[1];
  assign w_diff   = (w_sample != r_level);

  // Synchronizer and filter reset to the idle (released, high) level so
  // that leaving reset never produces a spurious falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_fall <= 1'b0;
      if (!w_diff) begin
        // Any agreeing sample restarts the run of disagreeing samples.
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        // This is the FILTER_LEN-th disagreeing sample in a row.
        r_level <= w_sample;
        r_cnt   <= '0;
        r_fall  <= r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level     = r_level;
  assign o_fall_tick = r_fall;

endmodule

// File: rtl/ps2_tx.sv
// ---------------------------------------------------------------------------
// ps2_tx
//   PS/2 host-to-device transmitter. Sends one command byte to the keyboard
//   using the request-to-send sequence: hold clock low, present the start
//   bit, then shift data on each device clock falling edge, release for the
//   stop bit and sample the device ACK. Lines are open-drain; this block
//   only asserts *_drive_low, pad tristating lives at top level.
//
// Handshake
//   tx_idle is the ready, wr_en the valid. A byte is accepted only in a
//   cycle where wr_en=1 and tx_idle=1; wr_en in any other cycle is dropped,
//   never queued. Every accepted byte ends with exactly one tx_done_tick
//   (tx_err marks missing ACK or timeout), and tx_idle returns to 1 the
//   cycle after that tick.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous reset, active-low
//   wr_en          in   start transmit of din (only when tx_idle=1)
//   din[7:0]       in   command byte
//   ps2c_in        in   PS/2 clock pad sample
//   ps2d_in        in   PS/2 data pad sample
//   ps2c_drive_low out  1 = pull clock pad low
//   ps2d_drive_low out  1 = pull data pad low
//   tx_idle        out  ready for wr_en
//   tx_done_tick   out  one-cycle pulse at end of each transaction
//   tx_err         out  one-cycle pulse with tx_done_tick on failure
//   dbg_state[2:0] out  current FSM state (ps2_tx_state_e encoding)
// ---------------------------------------------------------------------------
module ps2_tx
  import ps2_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_drive_low,
  output logic       ps2d_drive_low,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err,
  output logic [2:0] dbg_state
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  // -------------------------------------------------------------------------
  // Line conditioning
  // -------------------------------------------------------------------------
  logic       w_c_level;
  logic       w_fall;
  logic [1:0] r_d_sync;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_c_filter (
    .clk         (clk),
    .rst         (rst),
    .i_line      (ps2c_in),
    .o_level     (w_c_level),
    .o_fall_tick (w_fall)
  );

  // Data only needs synchronizing: it is sampled on filtered clock events,
  // long after it has settled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_d_sync <= 2'b11;
    else      r_d_sync <= {r_d_sync[0], ps2d_in};
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  ps2_tx_state_e    r_state;
  ps2_tx_state_e    w_state_nxt;
  logic [8:0]       r_frame;     // {parity, data}; bit 0 is on the wire
  logic [3:0]       r_bit_cnt;   // shifts left before parity is on the wire
  logic [INH_W-1:0] r_inh_cnt;
  logic [WD_W-1:0]  r_wdog;
  logic             r_nack;
  logic             r_c_low;
  logic             r_d_low;
  logic             r_done;
  logic             r_err;

  logic w_d_low_nxt;
  logic w_done_nxt;
  logic w_err_nxt;
  logic w_load;
  logic w_shift;
  logic w_cnt_load;
  logic w_ack_sample;
  logic w_wd_active;
  logic w_timeout;

  assign w_wd_active = (r_state == ST_START) || (r_state == ST_DATA) ||
                       (r_state == ST_STOP)  || (r_state == ST_ACK)  ||
                       (r_state == ST_WAIT_REL);

  // A fall_tick in the same cycle restarts the watchdog rather than firing.
  assign w_timeout = w_wd_active && !w_fall &&
                     (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_d_low_nxt  = r_d_low;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_cnt_load   = 1'b0;
    w_ack_sample = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_d_low_nxt = 1'b0;
        // r_done is high in the first IDLE cycle; tx_idle is still 0 then.
        if (wr_en && !r_done) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RTS;
        end
      end

      ST_RTS: begin
        // Our own clock pull-down produces fall_ticks here; they are ignored.
        if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          w_state_nxt = ST_START;
          w_d_low_nxt = 1'b1;           // start bit 0
        end
      end

      ST_START: begin
        if (w_fall) begin
          w_state_nxt = ST_DATA;
          w_d_low_nxt = ~r_frame[0];
          w_cnt_load  = 1'b1;
        end
      end

      ST_DATA: begin
        if (w_fall) begin
          if (r_bit_cnt != 4'd0) begin
            w_shift     = 1'b1;
            w_d_low_nxt = ~r_frame[1];
          end else begin
            // Parity has been clocked out: release for the stop bit.
            w_d_low_nxt = 1'b0;
            w_state_nxt = ST_STOP;
          end
        end
      end

      ST_STOP: begin
        if (w_fall) w_state_nxt = ST_ACK;
      end

      ST_ACK: begin
        if (w_fall) begin
          w_ack_sample = 1'b1;
          w_state_nxt  = ST_WAIT_REL;
        end
      end

      ST_WAIT_REL: begin
        if (w_c_level && r_d_sync[1]) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = r_nack;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_d_low_nxt = 1'b0;
      end
    endcase

    if (w_timeout) begin
      w_state_nxt = ST_IDLE;
      w_d_low_nxt = 1'b0;
      w_done_nxt  = 1'b1;
      w_err_nxt   = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Sequential logic
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_c_low <= 1'b0;
      r_d_low <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Registered pad controls keep decode glitches off the open-drain lines.
      r_c_low <= (w_state_nxt == ST_RTS);
      r_d_low <= w_d_low_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame   <= '0;
      r_bit_cnt <= '0;
      r_nack    <= 1'b0;
    end else begin
      if (w_load) begin
        r_frame <= {odd_parity(din), din};
        r_nack  <= 1'b0;
      end else if (w_shift) begin
        r_frame <= {1'b1, r_frame[8:1]};
      end

      if (w_cnt_load)   r_bit_cnt <= 4'd8;
      else if (w_shift) r_bit_cnt <= r_bit_cnt - 1'b1;

      // Device holds data low for ACK; high here means no acknowledge.
      if (w_ack_sample) r_nack <= r_d_sync[1];
    end
  end

  // Inhibit counter: runs only while in RTS, so it starts from 0 each time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_inh_cnt <= '0;
    else if (r_state == ST_RTS) r_inh_cnt <= r_inh_cnt + 1'b1;
    else                       r_inh_cnt <= '0;
  end

  // Watchdog: held at 0 outside the device-clocked states, so it is 0 in
  // the first START cycle; every device clock edge restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_wdog <= '0;
    else if (!w_wd_active) r_wdog <= '0;
    else if (w_fall)      r_wdog <= '0;
    else                  r_wdog <= r_wdog + 1'b1;
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ps2c_drive_low = r_c_low;
  assign ps2d_drive_low = r_d_low;
  assign tx_idle        = (r_state == ST_IDLE) && !r_done;
  assign tx_done_tick   = r_done;
  assign tx_err         = r_err;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_ps2_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_tx
//   Directed bench for ps2_tx with a behavioural PS/2 device. Parameters are
//   scaled down (INHIBIT 100, TIMEOUT 2000, device half-period 20 cycles)
//   to keep the run short; the protocol sequence is unchanged.
// ---------------------------------------------------------------------------
module tb_ps2_tx;
  import ps2_tx_pkg::*;

  localparam int INH  = 100;
  localparam int FLEN = 8;
  localparam int TOUT = 2000;
  localparam int HALF = 20;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] din;
  logic       ps2c_pad;
  logic       ps2d_pad;
  logic       ps2c_drive_low;
  logic       ps2d_drive_low;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       tx_err;
  logic [2:0] dbg_state;
  logic       dev_c_low;
  logic       dev_d_low;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Open-drain pads with pull-ups: low if either side pulls low.
  assign ps2c_pad = ~(ps2c_drive_low | dev_c_low);
  assign ps2d_pad = ~(ps2d_drive_low | dev_d_low);

  ps2_tx #(
    .INHIBIT_CYCLES (INH),
    .FILTER_LEN     (FLEN),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .din            (din),
    .ps2c_in        (ps2c_pad),
    .ps2d_in        (ps2d_pad),
    .ps2c_drive_low (ps2c_drive_low),
    .ps2d_drive_low (ps2d_drive_low),
    .tx_idle        (tx_idle),
    .tx_done_tick   (tx_done_tick),
    .tx_err         (tx_err),
    .dbg_state      (dbg_state)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [9:0] exp_q[$];

  always @(negedge clk) if (tx_done_tick) done_cnt++;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!tx_idle && n < 200) begin @(negedge clk); n++; end
    check("wait_idle", tx_idle, 1);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    din   = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Returns the number of cycles ps2c_drive_low stayed high; ends on the
  // first cycle after the clock line is released (first START cycle).
  task automatic wait_rts(output int len);
    int n = 0;
    len = 0;
    while (!ps2c_drive_low && n < 50) begin @(negedge clk); n++; end
    check("rts_seen", ps2c_drive_low, 1);
    while (ps2c_drive_low && len < INH + 100) begin @(negedge clk); len++; end
  endtask

  typedef struct {
    logic [7:0] din;
    logic       ack;
    int         intr_k;     // device clock during which a stray wr_en is sent
    logic [9:0] exp_frame;  // {stop, parity, data} as seen on rising edges
    logic       exp_err;
  } tx_vec_t;

  task automatic run_tx(input tx_vec_t v);
    int len;
    int done0;
    int n;
    logic [9:0] obs;
    logic [9:0] exp_f;
    obs   = '0;
    done0 = done_cnt;
    exp_q.push_back(v.exp_frame);
    wait_idle();
    send(v.din);
    wait_rts(len);
    check("rts_len", len, INH);
    check("start_bit", ps2d_drive_low, 1);
    wait_cycles(HALF);
    for (int k = 1; k <= 12; k++) begin
      dev_c_low = 1'b1;
      if (k == v.intr_k) begin
        check("busy_idle", tx_idle, 0);
        wr_en = 1'b1;
        din   = 8'h55;
        @(negedge clk);
        wr_en = 1'b0;
      end
      wait_cycles(HALF);
      dev_c_low = 1'b0;
      if (k <= 10) obs[k-1] = ps2d_pad;
      if (k == 10 && v.ack) dev_d_low = 1'b1;
      if (k == 12) dev_d_low = 1'b0;
      if (k < 12) wait_cycles(HALF);
    end
    n = 0;
    while (!tx_done_tick && n < 100) begin @(negedge clk); n++; end
    check("done_seen", tx_done_tick, 1);
    check("tx_err", tx_err, v.exp_err);
    @(negedge clk);
    check("idle_after_done", tx_idle, 1);
    check("done_one_cycle", tx_done_tick, 0);
    exp_f = exp_q.pop_front();
    check("frame", obs, exp_f);
    wait_cycles(30);
    check("no_queued_tx", ps2c_drive_low, 0);
    check("done_count", done_cnt - done0, 1);
  endtask

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  tx_vec_t vecs[5];

  initial begin
    int len;
    int n;
    rst       = 1'b0;
    wr_en     = 1'b0;
    din       = 8'h00;
    dev_c_low = 1'b0;
    dev_d_low = 1'b0;

    vecs[0] = '{din: CMD_SET_LED, ack: 1'b1, intr_k: 0, exp_frame: 10'h3ED, exp_err: 1'b0};
    vecs[1] = '{din: 8'h07,       ack: 1'b1, intr_k: 0, exp_frame: 10'h207, exp_err: 1'b0};
    vecs[2] = '{din: CMD_RESET,   ack: 1'b0, intr_k: 0, exp_frame: 10'h3FF, exp_err: 1'b1};
    vecs[3] = '{din: CMD_ENABLE,  ack: 1'b1, intr_k: 5, exp_frame: 10'h2F4, exp_err: 1'b0};
    vecs[4] = '{din: 8'h00,       ack: 1'b1, intr_k: 0, exp_frame: 10'h300, exp_err: 1'b0};

    wait_cycles(5);
    check("rst_idle", tx_idle, 1);
    check("rst_c_low", ps2c_drive_low, 0);
    check("rst_d_low", ps2d_drive_low, 0);
    check("rst_done", tx_done_tick, 0);
    check("rst_err", tx_err, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b1;
    wait_cycles(5);

    for (int i = 0; i < 5; i++) run_tx(vecs[i]);

    // Device never clocks: watchdog fires TOUT cycles after START entry.
    wait_idle();
    send(CMD_ENABLE);
    wait_rts(len);
    check("to_rts_len", len, INH);
    n = 0;
    while (!tx_done_tick && n < TOUT + 50) begin @(negedge clk); n++; end
    check("to_latency", n, TOUT);
    check("to_err", tx_err, 1);
    check("to_c_rel", ps2c_drive_low, 0);
    check("to_d_rel", ps2d_drive_low, 0);
    @(negedge clk);
    check("to_idle_next", tx_idle, 1);

    // Asynchronous reset in the middle of DATA while data is pulled low.
    wait_idle();
    send(CMD_SET_LED);
    wait_rts(len);
    wait_cycles(HALF);
    dev_c_low = 1'b1; wait_cycles(HALF);
    dev_c_low = 1'b0; wait_cycles(HALF);
    dev_c_low = 1'b1; wait_cycles(15);
    check("mid_state_data", dbg_state, 3);
    check("mid_d_low", ps2d_drive_low, 1);   // bit1 of 0xED is 0
    #2 rst = 1'b0;
    #1;
    check("async_d_rel", ps2d_drive_low, 0);
    check("async_c_rel", ps2c_drive_low, 0);
    check("async_idle", tx_idle, 1);
    dev_c_low = 1'b0;
    wait_cycles(5);
    rst = 1'b1;
    wait_cycles(5);
    run_tx(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- PS/2 host-to-device transmitter, the send-side counterpart of the keyboard receiver path.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Lines are open-drain: the block only ever drives low or releases; pad tristating happens at top level.
- tx_idle gates the receiver's rx_en so receive and transmit never overlap.

Parameters:
- INHIBIT_CYCLES, 10000: cycles clk line is held low before the start bit (100 µs at 100 MHz).
- FILTER_LEN, 8: consecutive equal samples needed to change the filtered ps2c level.
- TIMEOUT_CYCLES, 2000000: maximum cycles without a device clock falling edge before abort (20 ms).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- wr_en  in  1  start transmit of din; honoured only when tx_idle=1
- din  in  8  command byte
- ps2c_in  in  1  sampled PS/2 clock pad
- ps2d_in  in  1  sampled PS/2 data pad
- ps2c_drive_low  out  1  1 = pull clock pad low, 0 = release
- ps2d_drive_low  out  1  1 = pull data pad low, 0 = release
- tx_idle  out  1  1 when ready for wr_en
- tx_done_tick  out  1  one-cycle pulse at end of every transaction (success or fail)
- tx_err  out  1  one-cycle pulse coincident with tx_done_tick when ACK is missing or timeout occurs

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; both drive_low outputs 0 (lines released immediately, including mid-frame); tx_idle=1; tick and err outputs 0; counters and shift register cleared.
- ps2c path: 2-FF synchronizer, then FILTER_LEN-deep filter. Filtered level goes to 0 only after FILTER_LEN consecutive 0 samples, and to 1 only after FILTER_LEN consecutive 1s. fall_tick is a one-cycle pulse on each filtered 1->0 transition.
- ps2d path: 2-FF synchronizer only.
- On wr_en with tx_idle=1:
  - latch frame {parity, din}, parity = ~^din (odd parity);
  - next cycle: state RTS, tx_idle=0.
- wr_en while busy is ignored; the frame is not queued.
- RTS:
  - ps2c_drive_low=1, ps2d_drive_low=0, for exactly INHIBIT_CYCLES cycles.
  - Then go to START: ps2c_drive_low=0, ps2d_drive_low=1 (start bit 0).
  - fall_tick is ignored while in RTS.
- START: on fall_tick, present bit0: ps2d_drive_low = ~frame[0]. Go to DATA with bit count 8.
- DATA: each fall_tick shifts the frame and presents the next bit, LSB first, parity last. On the fall_tick after parity is presented, release data (stop bit 1) and go to STOP.
- STOP: on next fall_tick go to ACK.
- ACK: on next fall_tick sample the synchronized ps2d:
  - ps2d=0: device acknowledged; go to WAIT_REL.
  - ps2d=1: flag error; go to WAIT_REL.
- WAIT_REL: wait until filtered ps2c=1 and synchronized ps2d=1. Then pulse tx_done_tick (plus tx_err if flagged) and return to IDLE; tx_idle=1 the following cycle.
- Watchdog:
  - counts in START, DATA, STOP, ACK and WAIT_REL;
  - cleared on entering START and on each fall_tick;
  - on reaching TIMEOUT_CYCLES: release both lines, pulse tx_done_tick and tx_err together, go to IDLE.
- Simultaneous wr_en and a pending tx_done_tick: not possible, since tx_idle=0 until the cycle after the tick.
- Per bit, the host changes data only in the cycle after fall_tick; the device samples on the rising edge.

Decomposition:
- ps2_defs.vh holds:
  - state encodings IDLE, RTS, START, DATA, STOP, ACK, WAIT_REL (3-bit);
  - keyboard command constants CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4;
  - ACK_BYTE=8'hFA;
  - shared with the receiver: BREAK=8'hF0.
- One sub-module, ps2_line_filter: synchronizer, FILTER_LEN debounce, fall_tick. Reusable by the receiver.

Test Plan:
- Send 0xED (6 ones), with a bench device model clocking at 12.5 kHz and ACK low: ps2c_drive_low is high for exactly 10000 cycles. Data bits observed on device rising edges are 1,0,1,1,0,1,1,1, then parity 1, then stop 1. tx_done_tick=1, tx_err=0.
- Send 0x07 (3 ones): parity bit observed is 0. Frame otherwise correct; no error.
- Device never pulls data low in the ACK slot (send 0xFF): tx_done_tick and tx_err pulse in the same cycle; tx_idle=1 on the next cycle.
- Device never clocks after RTS: exactly TIMEOUT_CYCLES cycles after START entry, both lines are released and tx_done_tick + tx_err pulse.
- wr_en with 0x55 asserted during DATA of a 0xF4 transfer: the transmitted frame is still 0xF4 and only one tx_done_tick occurs.
- Assert rst low mid-DATA: both drive_low outputs drop in the same cycle (async); tx_idle=1. A new 0xED after rst release completes normally.
